// File: rtl/modadd_ctrl.sv
// rtl/modadd_ctrl.sv - modular add/subtract sequencer driving a shared 1-cycle carry-select adder
module modadd_ctrl #(
  parameter int WIDTH = 1027
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             adder_sub,
  output logic [WIDTH-1:0] adder_a,
  output logic [WIDTH-1:0] adder_b,
  output logic [WIDTH-1:0] adder_c,
  input  logic [WIDTH:0]   adder_result
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE1 = 3'd1;
  localparam logic [2:0] S_CAP1   = 3'd2;
  localparam logic [2:0] S_ISSUE2 = 3'd3;
  localparam logic [2:0] S_CAP2   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]       state;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] r1_q;
  logic             op_q;
  logic             borrow1_q;

  assign adder_c = '0;

  // Adder operands are loaded on the edge entering each ISSUE state so they are
  // registered outputs, present on the adder inputs for the whole ISSUE cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      adder_sub <= 1'b0;
      adder_a   <= '0;
      adder_b   <= '0;
      m_q       <= '0;
      r1_q      <= '0;
      op_q      <= 1'b0;
      borrow1_q <= 1'b0;
    end else begin
      done      <= 1'b0;
      adder_sub <= 1'b0;
      adder_a   <= '0;
      adder_b   <= '0;
      case (state)
        S_IDLE: begin
          if (start) begin
            m_q       <= in_m;
            op_q      <= op;
            adder_a   <= in_a;
            adder_b   <= in_b;
            adder_sub <= op;
            busy      <= 1'b1;
            state     <= S_ISSUE1;
          end
        end
        S_ISSUE1: state <= S_CAP1;
        S_CAP1: begin
          r1_q      <= adder_result[WIDTH-1:0];
          borrow1_q <= adder_result[WIDTH];
          // Second pass: add mode trial-subtracts M, sub mode adds M back.
          adder_a   <= adder_result[WIDTH-1:0];
          adder_b   <= m_q;
          adder_sub <= ~op_q;
          state     <= S_ISSUE2;
        end
        S_ISSUE2: state <= S_CAP2;
        S_CAP2: begin
          if (!op_q) begin
            result <= adder_result[WIDTH] ? r1_q : adder_result[WIDTH-1:0];
          end else begin
            result <= borrow1_q ? adder_result[WIDTH-1:0] : r1_q;
          end
          done  <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/modadd_ctrl.md
Name: modadd_ctrl

Overview:
- Sequencer that computes modular add or modular subtract on 1027-bit operands: (A+B) mod M or (A−B) mod M.
- Uses one shared instance of the two-stage carry-select adder/subtractor. That adder has 1-cycle latency: operands are registered at the clock edge and the result is valid combinationally in the next cycle.
- Sits beside the Montgomery multiplier datapath. Provides the final conditional-subtract/add-back step and standalone modular add/sub for the top-level controller.

Parameters:
- WIDTH, 1027, operand width; fixed by the adder (the adder result is WIDTH+1 bits).

Ports:
- clk  in  1  clock, all state updates on posedge
- resetn  in  1  asynchronous active-low reset
- start  in  1  request pulse; sampled only in IDLE
- op  in  1  0 = modular add, 1 = modular subtract; latched with start
- in_a  in  WIDTH  operand A; requires A < M
- in_b  in  WIDTH  operand B; requires B < M
- in_m  in  WIDTH  modulus M; requires M < 2^(WIDTH−1)
- busy  out  1  high from the cycle after start is accepted until done, inclusive
- done  out  1  one-cycle pulse; result valid in that cycle
- result  out  WIDTH  final value, held until the next accepted start
- adder_sub  out  1  drives the adder subtract input
- adder_a  out  WIDTH  drives adder in_a
- adder_b  out  WIDTH  drives adder in_b
- adder_c  out  WIDTH  drives adder in_c; constant 0
- adder_result  in  WIDTH+1  adder result; bit WIDTH is carry-out on add and borrow on subtract

Behaviour:
- Reset (async, resetn=0): state=IDLE; busy=0, done=0, result=0; adder_sub=0, adder_a=0, adder_b=0, adder_c=0; internal regs (A, B, M, op, R1, borrow1) cleared.
- States: IDLE → ISSUE1 → CAP1 → ISSUE2 → CAP2 → DONE → IDLE. All transitions are unconditional except IDLE.
- IDLE:
  - On start=1, latch in_a, in_b, in_m, op and go to ISSUE1.
  - start while not in IDLE is ignored; there is no queueing.
- ISSUE1: adder_a=A, adder_b=B, adder_sub=op.
- CAP1:
  - R1 ← adder_result[WIDTH−1:0].
  - borrow1 ← adder_result[WIDTH].
  - In add mode borrow1 is always 0, given the operand range.
- ISSUE2:
  - add mode: adder_a=R1, adder_b=M, adder_sub=1.
  - sub mode: adder_a=R1, adder_b=M, adder_sub=0.
- CAP2, add mode:
  - adder_result[WIDTH]=1 (S<M): result ← R1.
  - otherwise: result ← adder_result[WIDTH−1:0].
  - S=M gives result=0.
- CAP2, sub mode:
  - borrow1=1: result ← adder_result[WIDTH−1:0], i.e. (R1+M) mod 2^WIDTH.
  - borrow1=0: result ← R1.
- DONE: done=1 for exactly one cycle, then IDLE. The step-2 adder pass always executes, so latency is fixed.
- Latency: start sampled at edge k → done high in cycle k+5. Back-to-back throughput is one operation per 6 cycles.
- busy=1 in ISSUE1..DONE, 0 in IDLE.
- Adder drive outside ISSUE1/ISSUE2: adder_a=0, adder_b=0, adder_sub=0.
- All outputs are registered; no combinational path from start or in_* to any output.
- result changes only at the CAP2 edge.
- Reset asserted mid-operation: immediate IDLE, no done pulse, result=0. The next start after release runs normally.
- Out-of-range operands are not detected; the result is unspecified but the FSM still completes in 5 cycles.

Test Plan:
Bench instantiates the real adder with adder_* wired to it; M=13 unless stated.
- Add 7+9: result=3, done exactly 5 cycles after start, busy high for 5 cycles.
- Add 3+4 → 7; add 6+7 → 0 (S=M boundary); add 0+0 → 0.
- Sub 9−4 → 5; sub 4−9 → 8 (borrow add-back); sub 5−5 → 0.
- Wide values, M=2^1025+1:
  - Add A=B=2^1025 → 2^1025−1.
  - Sub 0−(2^1025) → 1.
  - Check bit 1026 handling.
- start held high for 12 cycles with add 1+1: exactly two operations complete (done at cycles 5 and 11). Changing in_* mid-operation does not affect result.
- Assert resetn=0 in CAP1 of add 7+9: busy/done/result go to 0 immediately; after release, sub 4−9 returns 8 with normal latency.
